// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher sequencer: owns the lit-lamp counter, walks the up/down phase
// program with flick kickback, and decodes the count into a thermometer lamp bus.
module bound_flasher_ctrl #(
    parameter int LAMPS  = 16,
    parameter int LOW_A  = 5,
    parameter int HIGH_B = 11,
    parameter int HIGH_C = 6,
    parameter int KB0    = 6,
    parameter int KB1    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             flick,
    input  logic             clr,
    output logic [LAMPS-1:0] lamp,
    output logic [4:0]       counter,
    output logic [2:0]       phase,
    output logic [1:0]       count_state,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP_A = 3'd1,
        DN_A = 3'd2,
        UP_B = 3'd3,
        DN_B = 3'd4,
        UP_C = 3'd5,
        DN_C = 3'd6,
        KB_A = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        CS_DIS  = 2'b00,
        CS_UP   = 2'b01,
        CS_DOWN = 2'b10,
        CS_HOLD = 2'b11
    } step_e;

    localparam logic [4:0] CNT_MAX = 5'(LAMPS);
    localparam logic [4:0] TGT_A   = 5'(LOW_A);
    localparam logic [4:0] TGT_B   = 5'(HIGH_B);
    localparam logic [4:0] TGT_C   = 5'(HIGH_C);
    localparam logic [4:0] KB0_CNT = 5'(KB0);
    localparam logic [4:0] KB1_CNT = 5'(KB1);

    phase_e      phase_q, phase_n, phase_sel;
    step_e       step;
    logic [4:0]  counter_q, counter_n;
    logic        done_q, done_n;
    logic        kick;

    // Count at which each phase hands over to its successor.
    function automatic logic [4:0] target_of(input phase_e p);
        logic [4:0] t;
        t = '0;
        case (p)
            UP_A:    t = CNT_MAX;
            DN_A:    t = TGT_A;
            UP_B:    t = TGT_B;
            UP_C:    t = TGT_C;
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic phase_e succ_of(input phase_e p);
        phase_e s;
        s = IDLE;
        case (p)
            UP_A:    s = DN_A;
            DN_A:    s = UP_B;
            UP_B:    s = DN_B;
            DN_B:    s = UP_C;
            UP_C:    s = DN_C;
            KB_A:    s = UP_A;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= IDLE;
            counter_q <= '0;
            done_q    <= 1'b0;
        end else begin
            phase_q   <= phase_n;
            counter_q <= counter_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        step      = CS_HOLD;
        phase_sel = phase_q;
        phase_n   = phase_q;
        counter_n = counter_q;
        done_n    = 1'b0;
        kick      = (phase_q == UP_A || phase_q == UP_B) && flick &&
                    (counter_q == KB0_CNT || counter_q == KB1_CNT);

        if (clr) begin
            step      = CS_DIS;
            phase_sel = IDLE;
        end else if (tick) begin
            unique case (phase_q)
                IDLE: begin
                    if (flick) begin
                        step      = CS_UP;
                        phase_sel = UP_A;
                    end else begin
                        step      = CS_DIS;
                    end
                end
                UP_A, UP_B: begin
                    if (kick) begin
                        step = CS_DOWN;
                        if (phase_q == UP_A) phase_sel = KB_A;
                        else                 phase_sel = DN_A;
                    end else begin
                        step = CS_UP;
                    end
                end
                UP_C:    step = CS_UP;
                default: step = CS_DOWN;
            endcase
        end

        case (step)
            CS_DIS:  counter_n = '0;
            CS_UP:   counter_n = counter_q + 5'd1;
            CS_DOWN: counter_n = counter_q - 5'd1;
            default: counter_n = counter_q;
        endcase

        // Reaching the target hands over in the same edge; there is no dwell tick.
        phase_n = phase_sel;
        if (tick && !clr && phase_sel != IDLE && counter_n == target_of(phase_sel))
            phase_n = succ_of(phase_sel);

        done_n = !clr && (phase_q == DN_C) && (phase_n == IDLE);
    end

    always_comb begin
        lamp = '0;
        for (int i = 0; i < LAMPS; i++)
            lamp[i] = (5'(i) < counter_q);
        busy = (phase_q != IDLE);
    end

    assign counter     = counter_q;
    assign phase       = phase_q;
    assign count_state = step;
    assign done        = done_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) counter_q <= CNT_MAX);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(step == CS_DOWN && counter_q == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(step == CS_UP && counter_q == CNT_MAX));

endmodule
